// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int DATA_W = 8;

  // Opcode byte that introduces a two-byte unconditional branch.
  localparam logic [DATA_W-1:0] BRANCH_OP_DEFAULT = 8'hF0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    STEP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef enum logic {
    OPCODE = 1'b0,
    OFFSET = 1'b1
  } phase_t;

  // PC value that follows a step: pc+1, plus the signed offset when branching.
  function automatic logic [DATA_W-1:0] next_pc(
    input logic [DATA_W-1:0] pc,
    input logic              branch,
    input logic [DATA_W-1:0] offset
  );
    return pc + DATA_W'(1) + (branch ? offset : '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // Increment on enable unless already saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: reads one byte per fetch, hands it to the decoder,
// then steps the PC, recognising two-byte branches on the way.
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | read request outstanding at mem_addr, waiting for mem_ack
// ISSUE | byte presented to the decoder, waiting for instr_ready
// STEP  | one-cycle PC advance, pc_flags sampled
// FAULT | PC overflowed; everything idle until reset
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] BRANCH_OP = BRANCH_OP_DEFAULT,
  parameter int                LOOP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_address,
  input  logic [1:0]        pc_flags,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pc_step,
  output logic              sig_branch,
  output logic [DATA_W-1:0] branch_offset,
  output logic              fault,
  output logic [LOOP_W-1:0] loop_count
);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic              mem_req_d;
  logic [DATA_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] instr_d;
  logic              instr_valid_d;
  logic              pc_step_d;
  logic              sig_branch_d;
  logic [DATA_W-1:0] branch_offset_d;
  logic              fault_d;
  logic              loop_inc;

  // State, phase and every output are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      phase_q       <= OPCODE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      pc_step       <= 1'b0;
      sig_branch    <= 1'b0;
      branch_offset <= '0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
      instr         <= instr_d;
      instr_valid   <= instr_valid_d;
      pc_step       <= pc_step_d;
      sig_branch    <= sig_branch_d;
      branch_offset <= branch_offset_d;
      fault         <= fault_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    mem_req_d       = mem_req;
    mem_addr_d      = mem_addr;
    instr_d         = instr;
    instr_valid_d   = instr_valid;
    pc_step_d       = 1'b0;
    sig_branch_d    = 1'b0;
    branch_offset_d = '0;
    fault_d         = fault;
    loop_inc        = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!mem_req) begin
          // First fetch after reset: the PC is idle, so take it directly.
          mem_req_d  = 1'b1;
          mem_addr_d = pc_address;
        end else if (mem_ack) begin
          mem_req_d     = 1'b0;
          instr_d       = mem_data;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_step_d     = 1'b1;
          state_d       = STEP;
          if (phase_q == OFFSET) begin
            sig_branch_d    = 1'b1;
            branch_offset_d = instr;
            phase_d         = OPCODE;
          end else if (instr == BRANCH_OP) begin
            phase_d = OFFSET;
          end
        end
      end

      STEP: begin
        loop_inc = sig_branch & pc_flags[0];
        if (pc_flags[1]) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          // The PC moves on this same edge, so the next read address is the
          // value it is about to take; this keeps FETCH to a single cycle.
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = next_pc(pc_address, sig_branch, branch_offset);
        end
      end

      FAULT: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  sat_counter #(
    .W(LOOP_W)
  ) u_loop_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (loop_inc),
    .count(loop_count)
  );

endmodule
